// File: rtl/my_ycbcr.sv
// RGB (10-bit per component) to 8-bit YCbCr converter on AXI4-Stream video.
// Three-stage pipeline stalled as a whole by downstream ready.
module my_ycbcr (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser
);

  logic adv;
  assign adv                 = m_axis_video_tready;
  assign s_axis_video_tready = m_axis_video_tready;

  // Stage 1: truncated components and sideband
  logic [7:0] s1_r_q, s1_g_q, s1_b_q;
  logic       s1_valid_q, s1_last_q, s1_user_q;
  logic [7:0] s1_r_d, s1_g_d, s1_b_d;
  logic       s1_valid_d, s1_last_d, s1_user_d;

  // Stage 2: weighted sums
  logic        [16:0] s2_y_q, s2_y_d;
  logic signed [17:0] s2_cb_q, s2_cr_q, s2_cb_d, s2_cr_d;
  logic               s2_valid_q, s2_last_q, s2_user_q;

  // Stage 3: output registers
  logic [7:0] s3_y_q, s3_cb_q, s3_cr_q;
  logic [7:0] s3_y_d, s3_cb_d, s3_cr_d;
  logic       s3_valid_q, s3_last_q, s3_user_q;

  always_comb begin
    s1_r_d     = s_axis_video_tdata[29:22];
    s1_b_d     = s_axis_video_tdata[19:12];
    s1_g_d     = s_axis_video_tdata[9:2];
    s1_valid_d = s_axis_video_tvalid;
    s1_last_d  = s_axis_video_tlast;
    s1_user_d  = s_axis_video_tuser;
  end

  logic signed [17:0] r_s, g_s, b_s;

  always_comb begin
    r_s     = $signed({10'd0, s1_r_q});
    g_s     = $signed({10'd0, s1_g_q});
    b_s     = $signed({10'd0, s1_b_q});
    s2_y_d  = 17'd77 * {9'd0, s1_r_q} + 17'd150 * {9'd0, s1_g_q} + 17'd29 * {9'd0, s1_b_q};
    s2_cb_d = 18'sd128 * b_s - 18'sd43 * r_s - 18'sd85 * g_s;
    s2_cr_d = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s;
  end

  function automatic logic [7:0] clamp_s(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  logic signed [17:0] cb_off, cr_off;

  always_comb begin
    // Arithmetic shift floors toward minus infinity before the 128 offset
    cb_off  = (s2_cb_q >>> 8) + 18'sd128;
    cr_off  = (s2_cr_q >>> 8) + 18'sd128;
    s3_y_d  = s2_y_q[16] ? 8'd255 : s2_y_q[15:8];
    s3_cb_d = clamp_s(cb_off);
    s3_cr_d = clamp_s(cr_off);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_user_q  <= 1'b0;
      s2_y_q     <= '0;
      s2_cb_q    <= '0;
      s2_cr_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_user_q  <= 1'b0;
      s3_y_q     <= '0;
      s3_cb_q    <= '0;
      s3_cr_q    <= '0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_user_q  <= 1'b0;
    end else if (adv) begin
      s1_r_q     <= s1_r_d;
      s1_g_q     <= s1_g_d;
      s1_b_q     <= s1_b_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_user_q  <= s1_user_d;
      s2_y_q     <= s2_y_d;
      s2_cb_q    <= s2_cb_d;
      s2_cr_q    <= s2_cr_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_user_q  <= s1_user_q;
      s3_y_q     <= s3_y_d;
      s3_cb_q    <= s3_cb_d;
      s3_cr_q    <= s3_cr_d;
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      s3_user_q  <= s2_user_q;
    end
  end

  assign m_axis_video_tdata  = {s3_cr_q, s3_cb_q, s3_y_q};
  assign m_axis_video_tvalid = s3_valid_q;
  assign m_axis_video_tlast  = s3_last_q;
  assign m_axis_video_tuser  = s3_user_q;

  // Discarded input LSBs and fraction bits of the luma sum
  logic unused_bits;
  assign unused_bits = ^{s_axis_video_tdata[31:30], s_axis_video_tdata[21:20],
                         s_axis_video_tdata[11:10], s_axis_video_tdata[1:0], s2_y_q[7:0]};

endmodule

// File: tb/tb_my_ycbcr.sv
// Scoreboard bench for my_ycbcr: driver pushes expected beats, negedge monitor pops and compares.
module tb_my_ycbcr;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic        s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        m_tready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        user;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  my_ycbcr dut (
    .clk                 (clk),
    .rstn                (rstn),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tready (s_tready),
    .s_axis_video_tlast  (s_tlast),
    .s_axis_video_tuser  (s_tuser),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tready (m_tready),
    .m_axis_video_tlast  (m_tlast),
    .m_axis_video_tuser  (m_tuser)
  );

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [23:0] model(input logic [31:0] d);
    int r, g, b, y, cb, cr;
    r  = int'(d[29:22]);
    b  = int'(d[19:12]);
    g  = int'(d[9:2]);
    y  = clamp8((77 * r + 150 * g + 29 * b) / 256);
    cb = clamp8(((-43 * r - 85 * g + 128 * b) >>> 8) + 128);
    cr = clamp8(((128 * r - 107 * g - 21 * b) >>> 8) + 128);
    return {cr[7:0], cb[7:0], y[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle; a valid beat with ready high is accepted on the coming edge
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic u,
                      input logic rdy, input logic [23:0] exp);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    m_tready = rdy;
    if (v && rdy && rstn) sb_q.push_back('{data: exp, last: l, user: u});
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 1'b0, rdy, 24'h0);
  endtask

  // Monitor
  logic [25:0] snap;
  logic        hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_outputs", {5'd0, m_tvalid, m_tlast, m_tuser, m_tdata}, 32'h0);
      hold_prev <= 1'b0;
    end else begin
      check("tready_passthru", {31'd0, s_tready}, {31'd0, m_tready});
      if (hold_prev)
        check("frozen_outputs", {6'd0, m_tvalid, m_tlast, m_tdata}, {6'd0, snap});
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_tdata);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("beat", {6'd0, m_tdata, m_tlast, m_tuser}, {6'd0, e.data, e.last, e.user});
        end
      end
      snap      <= {m_tvalid, m_tlast, m_tdata};
      hold_prev <= !m_tready;
    end
  end

  initial begin
    logic [31:0] d;
    logic        v, rdy;
    rstn     = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    bubble(1'b1);

    // Latency of white pixel: accepted at edge N, visible after N+2
    step(1'b1, 32'h3FFF_FFFF, 1'b0, 1'b1, 1'b1, 24'h8080FF);
    bubble(1'b1);
    check("latency_not_early", {31'd0, m_tvalid}, 32'd0);
    bubble(1'b1);
    check("latency_valid", {31'd0, m_tvalid}, 32'd1);
    check("white_data", {8'd0, m_tdata}, 32'h8080FF);

    // Directed colours with hand-derived expectations
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 24'h808000);
    step(1'b1, 32'h3FF0_0000, 1'b0, 1'b0, 1'b1, {8'd255, 8'd85, 8'd76});
    step(1'b1, 32'h0000_03FF, 1'b0, 1'b0, 1'b1, {8'd21, 8'd43, 8'd149});
    step(1'b1, 32'h000F_FC00, 1'b1, 1'b0, 1'b1, {8'd107, 8'd255, 8'd28});
    repeat (4) bubble(1'b1);

    // Randomized traffic with a forced 5-cycle stall mid-stream
    for (int i = 0; i < 400; i++) begin
      d   = $urandom;
      v   = ($urandom_range(3) != 0);
      rdy = ($urandom_range(3) != 0);
      if (i >= 200 && i < 205) begin
        v   = 1'b1;
        rdy = 1'b0;
      end
      step(v, d, 1'($urandom_range(1)), 1'($urandom_range(1)), rdy, model(d));
      if (i >= 200 && i < 205)
        check("stall_s_tready", {31'd0, s_tready}, 32'd0);
    end
    repeat (6) bubble(1'b1);
    check("drain_random", sb_q.size(), 32'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      step(1'b1, d, 1'b0, 1'b0, 1'b1, model(d));
    end
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check("reset_kills_valid", {31'd0, m_tvalid}, 32'd0);
    repeat (2) bubble(1'b1);
    rstn = 1'b1;

    // 16-beat line: tuser on first, tlast on last
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      step(1'b1, d, 1'(i == 15), 1'(i == 0), 1'b1, model(d));
    end
    repeat (6) bubble(1'b1);
    check("drain_line", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
